// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU pipeline
// (port C) and the host/debug loader (port H). Port C normally wins, but the
// host is never refused more than MAX_WAIT consecutive cycles. Read data
// returns from the SRAM one cycle after the access and is tagged to its owner.
module dmem_arbiter #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpuReq,
    input  logic              cpuWe,
    input  logic [ADDR_W-1:0] cpuAdrx,
    input  logic [DATA_W-1:0] cpuWrData,
    output logic              cpuGnt,
    output logic              cpuRdValid,
    output logic [DATA_W-1:0] cpuRdData,

    input  logic              hostReq,
    input  logic              hostWe,
    input  logic [ADDR_W-1:0] hostAdrx,
    input  logic [DATA_W-1:0] hostWrData,
    output logic              hostGnt,
    output logic              hostRdValid,
    output logic [DATA_W-1:0] hostRdData,

    output logic              memEn,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAdrx,
    output logic [DATA_W-1:0] memWrData,
    input  logic [DATA_W-1:0] memRdData
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] waitCnt_q;
    logic [WAIT_W-1:0] waitCnt_d;
    logic [1:0]        rdOwner_q;
    logic [1:0]        rdOwner_d;

    // Grant selection: a starved host beats the CPU, otherwise the CPU wins; nothing is granted in reset
    always_comb begin
        cpuGnt  = 1'b0;
        hostGnt = 1'b0;
        if (!reset) begin
            if (hostReq && (waitCnt_q == WAIT_LIMIT)) begin
                hostGnt = 1'b1;
            end else if (cpuReq) begin
                cpuGnt = 1'b1;
            end else if (hostReq) begin
                hostGnt = 1'b1;
            end
        end
    end

    // Steer the granted port onto the SRAM bus; an idle bus is driven to all zeros
    always_comb begin
        memEn     = cpuGnt | hostGnt;
        memWe     = 1'b0;
        memAdrx   = '0;
        memWrData = '0;
        if (cpuGnt) begin
            memWe     = cpuWe;
            memAdrx   = cpuAdrx;
            memWrData = cpuWrData;
        end else if (hostGnt) begin
            memWe     = hostWe;
            memAdrx   = hostAdrx;
            memWrData = hostWrData;
        end
    end

    // Next state: count consecutive host refusals (saturating) and remember who owns the returning read
    always_comb begin
        waitCnt_d = '0;
        if (hostReq && !hostGnt) begin
            waitCnt_d = (waitCnt_q == WAIT_LIMIT) ? WAIT_LIMIT : waitCnt_q + WAIT_W'(1);
        end
        rdOwner_d = {cpuGnt & ~cpuWe, hostGnt & ~hostWe};
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            waitCnt_q <= '0;
            rdOwner_q <= '0;
        end else begin
            waitCnt_q <= waitCnt_d;
            rdOwner_q <= rdOwner_d;
        end
    end

    // Read return; valid is masked while reset is high so a read issued just before reset is dropped
    assign cpuRdValid  = rdOwner_q[1] & ~reset;
    assign hostRdValid = rdOwner_q[0] & ~reset;
    assign cpuRdData   = memRdData;
    assign hostRdData  = memRdData;

endmodule
